// File: rtl/avr_fetch_q_pkg.sv
// Shared definitions for the AVR front end (fetch and decode).
//   PC_SRC_*     : pc_src encodings driven by decode
//   is_two_word  : true for the first word of a 32-bit AVR instruction
package avr_fetch_q_pkg;

    localparam logic [2:0] PC_SRC_HOLD    = 3'b000;
    localparam logic [2:0] PC_SRC_ADV     = 3'b010;
    localparam logic [2:0] PC_SRC_JMP_ABS = 3'b100;
    localparam logic [2:0] PC_SRC_JMP_REL = 3'b101;

    // JMP/CALL carry a 16-bit target word; LDS/STS carry a 16-bit data address.
    function automatic logic is_two_word(input logic [15:0] w);
        return ((w & 16'hFE0C) == 16'h940C) || ((w & 16'hFC0F) == 16'h9000);
    endfunction

endpackage

// File: rtl/avr_fetch_q_fifo.sv
// Circular prefetch queue of {pc, word} entries.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   flush_i         : discard all entries; a simultaneous push becomes the sole entry
//   push_i          : append {push_pc_i, push_word_i}
//   pop_i           : drop 0, 1 or 2 entries from the head (ignored on flush)
//   head_pc_o       : pc of the head entry
//   head_word_o     : word of the head entry
//   head1_word_o    : word of the entry behind the head
//   count_o         : number of valid entries
module avr_fetch_q_fifo
    import avr_fetch_q_pkg::*;
#(
    parameter int unsigned PC_W  = 16,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            push_i,
    input  logic [PC_W-1:0] push_pc_i,
    input  logic [15:0]     push_word_i,
    input  logic [1:0]      pop_i,
    output logic [PC_W-1:0] head_pc_o,
    output logic [15:0]     head_word_o,
    output logic [15:0]     head1_word_o,
    output logic [CntW-1:0] count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [PC_W-1:0] pc_q   [DEPTH];
    logic [15:0]     word_q [DEPTH];
    logic [PtrW-1:0] rd_q, rd_d, wr_q, wr_d, wr_idx;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Modular pointer add; n <= 2 and DEPTH >= 2, so one subtraction suffices.
    function automatic logic [PtrW-1:0] ptr_add(input logic [PtrW-1:0] p, input logic [1:0] n);
        logic [PtrW:0] s;
        s = {1'b0, p} + (PtrW + 1)'(n);
        if (s >= (PtrW + 1)'(DEPTH)) begin
            s = s - (PtrW + 1)'(DEPTH);
        end
        return s[PtrW-1:0];
    endfunction

    always_comb begin
        rd_d   = rd_q;
        wr_d   = wr_q;
        cnt_d  = cnt_q;
        wr_idx = wr_q;
        if (flush_i) begin
            wr_idx = '0;
            rd_d   = '0;
            wr_d   = push_i ? ptr_add('0, 2'd1) : '0;
            cnt_d  = CntW'(push_i);
        end else begin
            rd_d  = ptr_add(rd_q, pop_i);
            wr_d  = push_i ? ptr_add(wr_q, 2'd1) : wr_q;
            cnt_d = cnt_q - CntW'(pop_i) + CntW'(push_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Payload storage needs no reset: count gates every use of it.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            pc_q[wr_idx]   <= push_pc_i;
            word_q[wr_idx] <= push_word_i;
        end
    end

    assign head_pc_o    = pc_q[rd_q];
    assign head_word_o  = word_q[rd_q];
    assign head1_word_o = word_q[ptr_add(rd_q, 2'd1)];
    assign count_o      = cnt_q;

endmodule

// File: rtl/avr_fetch_q.sv
// Prefetching instruction fetch unit for the AVR core.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   pc_src_i       : HOLD / ADV / JMP_ABS / JMP_REL from decode (others = HOLD)
//   jmp_i          : absolute target or sign-extended relative offset
//   prog_addr_o    : combinational program-memory word address
//   prog_data_i    : program word at prog_addr_o, same cycle
//   cur_instr_o    : head word (0 when not valid)
//   next_word_o    : second word of a two-word head instruction, else 0
//   instr_pc_o     : word address of cur_instr_o
//   instr_len_o    : 1 when the head instruction is two words
//   instr_valid_o  : head instruction fully present in the queue
module avr_fetch_q
    import avr_fetch_q_pkg::*;
#(
    parameter int unsigned     PC_W      = 16,
    parameter int unsigned     DEPTH     = 4,
    parameter logic [PC_W-1:0] RESET_VEC = '0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [2:0]      pc_src_i,
    input  logic [PC_W-1:0] jmp_i,
    output logic [PC_W-1:0] prog_addr_o,
    input  logic [15:0]     prog_data_i,
    output logic [15:0]     cur_instr_o,
    output logic [15:0]     next_word_o,
    output logic [PC_W-1:0] instr_pc_o,
    output logic            instr_len_o,
    output logic            instr_valid_o
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [PC_W-1:0] fpc_q, fpc_d;
    logic [PC_W-1:0] head_pc, target;
    logic [15:0]     head_word, head1_word;
    logic [CntW-1:0] count;
    logic [1:0]      pop;
    logic            head_two, valid, redirect, fetch_en;

    avr_fetch_q_fifo #(
        .PC_W  (PC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (redirect),
        .push_i       (fetch_en),
        .push_pc_i    (prog_addr_o),
        .push_word_i  (prog_data_i),
        .pop_i        (redirect ? 2'd0 : pop),
        .head_pc_o    (head_pc),
        .head_word_o  (head_word),
        .head1_word_o (head1_word),
        .count_o      (count)
    );

    always_comb begin
        head_two = is_two_word(head_word);
        valid    = (count != '0) && (!head_two || count >= CntW'(2));
        redirect = (pc_src_i == PC_SRC_JMP_ABS) || ((pc_src_i == PC_SRC_JMP_REL) && valid);
        target   = (pc_src_i == PC_SRC_JMP_ABS) ? jmp_i : head_pc + PC_W'(1) + jmp_i;
        pop      = ((pc_src_i == PC_SRC_ADV) && valid) ? (head_two ? 2'd2 : 2'd1) : 2'd0;
        // A redirect always fetches the target into the freshly flushed queue.
        fetch_en = redirect || (count < CntW'(DEPTH)) || (pop != 2'd0);
        prog_addr_o = redirect ? target : fpc_q;
        fpc_d = fpc_q;
        if (redirect) begin
            fpc_d = target + PC_W'(1);
        end else if (fetch_en) begin
            fpc_d = fpc_q + PC_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fpc_q <= RESET_VEC;
        end else begin
            fpc_q <= fpc_d;
        end
    end

    assign instr_valid_o = valid;
    assign instr_len_o   = valid && head_two;
    assign cur_instr_o   = valid ? head_word : 16'h0000;
    assign next_word_o   = (valid && head_two) ? head1_word : 16'h0000;
    assign instr_pc_o    = valid ? head_pc : '0;

endmodule

// File: tb/tb_avr_fetch_q.sv
module tb_avr_fetch_q;

    localparam int unsigned PC_W  = 16;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst2_n;
    logic [2:0]  pc_src, pc_src2;
    logic [15:0] jmp, jmp2;
    logic [15:0] prog_addr, prog_data, cur_instr, next_word, instr_pc;
    logic        instr_len, instr_valid;
    logic [15:0] prog_addr2, prog_data2, cur_instr2, next_word2, instr_pc2;
    logic        instr_len2, instr_valid2;

    logic [15:0] mem [0:65535];
    assign prog_data  = mem[prog_addr];
    assign prog_data2 = mem[prog_addr2];

    avr_fetch_q #(
        .PC_W      (PC_W),
        .DEPTH     (DEPTH),
        .RESET_VEC (16'h0000)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .pc_src_i      (pc_src),
        .jmp_i         (jmp),
        .prog_addr_o   (prog_addr),
        .prog_data_i   (prog_data),
        .cur_instr_o   (cur_instr),
        .next_word_o   (next_word),
        .instr_pc_o    (instr_pc),
        .instr_len_o   (instr_len),
        .instr_valid_o (instr_valid)
    );

    avr_fetch_q #(
        .PC_W      (PC_W),
        .DEPTH     (DEPTH),
        .RESET_VEC (16'hFFFE)
    ) dut2 (
        .clk_i         (clk),
        .rst_ni        (rst2_n),
        .pc_src_i      (pc_src2),
        .jmp_i         (jmp2),
        .prog_addr_o   (prog_addr2),
        .prog_data_i   (prog_data2),
        .cur_instr_o   (cur_instr2),
        .next_word_o   (next_word2),
        .instr_pc_o    (instr_pc2),
        .instr_len_o   (instr_len2),
        .instr_valid_o (instr_valid2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: queue of fetched word addresses plus the fetch pointer.
    logic [15:0] m_q[$];
    logic [15:0] m_fpc;

    function automatic bit tw(input logic [15:0] w);
        return ((w & 16'hFE0C) == 16'h940C) || ((w & 16'hFC0F) == 16'h9000);
    endfunction

    function automatic bit m_valid();
        if (m_q.size() == 0) return 1'b0;
        return !tw(mem[m_q[0]]) || (m_q.size() >= 2);
    endfunction

    // Check current DUT outputs against the model, then advance the model one clock.
    task automatic model_cycle(input logic [2:0] src, input logic [15:0] j);
        bit          v, two, redir, fetch;
        logic [15:0] tgt, ea;
        int          npop;
        v   = m_valid();
        two = v && tw(mem[m_q[0]]);
        check_eq("valid", instr_valid, v);
        check_eq("cur_instr", cur_instr, v ? mem[m_q[0]] : 16'h0000);
        check_eq("next_word", next_word, two ? mem[m_q[1]] : 16'h0000);
        if (v) begin
            check_eq("instr_pc", instr_pc, m_q[0]);
            check_eq("instr_len", instr_len, two);
        end
        redir = 1'b0;
        tgt   = 16'h0000;
        if (src == 3'b100) begin
            redir = 1'b1;
            tgt   = j;
        end else if (src == 3'b101 && v) begin
            redir = 1'b1;
            tgt   = m_q[0] + 16'd1 + j;
        end
        if (redir) begin
            ea = tgt;
            m_q.delete();
            m_q.push_back(tgt);
            m_fpc = tgt + 16'd1;
        end else begin
            ea    = m_fpc;
            npop  = (src == 3'b010 && v) ? (two ? 2 : 1) : 0;
            fetch = (m_q.size() < DEPTH) || (npop > 0);
            repeat (npop) void'(m_q.pop_front());
            if (fetch) begin
                m_q.push_back(m_fpc);
                m_fpc = m_fpc + 16'd1;
            end
        end
        check_eq("prog_addr", prog_addr, ea);
    endtask

    task automatic cyc(input logic [2:0] src, input logic [15:0] j);
        pc_src = src;
        jmp    = j;
        @(negedge clk);
        model_cycle(src, j);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        pc_src = 3'b000;
        jmp    = 16'h0000;
        rst_n  = 1'b0;
        #1;
        check_eq("rst_valid", instr_valid, 0);
        check_eq("rst_cur_instr", cur_instr, 0);
        check_eq("rst_next_word", next_word, 0);
        check_eq("rst_instr_pc", instr_pc, 0);
        check_eq("rst_instr_len", instr_len, 0);
        check_eq("rst_prog_addr", prog_addr, 16'h0000);
        m_q.delete();
        m_fpc = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic fill_directed();
        for (int i = 0; i < 65536; i++) mem[i] = 16'h1000 + 16'(i);
        mem[2]    = 16'h940C;
        mem[3]    = 16'h0050;
        mem[16'h60] = 16'h940C;
        mem[16'h61] = 16'h1234;
    endtask

    initial begin
        bit          seen;
        int unsigned r;
        logic [15:0] j;
        rst_n   = 1'b0;
        rst2_n  = 1'b0;
        pc_src  = 3'b000;
        jmp     = 16'h0000;
        pc_src2 = 3'b010;
        jmp2    = 16'h0000;
        fill_directed();
        @(posedge clk);
        #1;

        // Fill with HOLD: queue saturates, fetch address parks at 4.
        do_reset();
        repeat (8) cyc(3'b000, 16'h0000);
        check_eq("hold_prog_addr", prog_addr, 16'h0004);
        check_eq("hold_cur_instr", cur_instr, 16'h1000);
        check_eq("hold_instr_pc", instr_pc, 16'h0000);
        check_eq("hold_valid", instr_valid, 1);

        // Advance through a two-word instruction at pc 2.
        cyc(3'b010, 16'h0000);
        check_eq("adv_pc1", instr_pc, 16'h0001);
        cyc(3'b010, 16'h0000);
        check_eq("tw_instr_pc", instr_pc, 16'h0002);
        check_eq("tw_len", instr_len, 1);
        check_eq("tw_next_word", next_word, 16'h0050);
        cyc(3'b010, 16'h0000);
        check_eq("tw_after_pc", instr_pc, 16'h0004);

        // Absolute jump, relative jump back by 5, relative jump while not valid.
        cyc(3'b100, 16'h0050);
        check_eq("jabs_pc", instr_pc, 16'h0050);
        check_eq("jabs_instr", cur_instr, 16'h1050);
        check_eq("jabs_valid", instr_valid, 1);
        cyc(3'b101, 16'hFFFB);
        check_eq("jrel_pc", instr_pc, 16'h004C);
        cyc(3'b100, 16'h0060);
        check_eq("jtw_valid0", instr_valid, 0);
        cyc(3'b101, 16'h0010);
        check_eq("jrel_hold_valid", instr_valid, 1);
        check_eq("jrel_hold_pc", instr_pc, 16'h0060);
        check_eq("jrel_hold_next", next_word, 16'h1234);
        cyc(3'b010, 16'h0000);
        check_eq("jtw_after_pc", instr_pc, 16'h0062);

        // ADV every cycle from reset.
        do_reset();
        repeat (12) cyc(3'b010, 16'h0000);

        // Randomized program and control stream.
        rst_n = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            r = $urandom_range(0, 7);
            if (r == 0) mem[i] = 16'h940C | (16'($urandom) & 16'h01F2);
            else if (r == 1) mem[i] = 16'h9000 | (16'($urandom) & 16'h03F0);
            else mem[i] = 16'($urandom);
        end
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            r = $urandom_range(0, 99);
            if (r == 0) begin
                do_reset();
            end else begin
                r = $urandom_range(0, 9);
                j = 16'($urandom);
                if (r < 2) cyc(3'b000, j);
                else if (r < 7) cyc(3'b010, j);
                else if (r == 7) cyc(3'b100, j);
                else if (r == 8) cyc(3'b101, 16'(int'($urandom_range(0, 63)) - 32));
                else cyc(3'($urandom_range(0, 1) != 0 ? 3'b111 : 3'b011), j);
            end
        end

        // Second instance: reset vector near the top of the address space.
        rst_n = 1'b0;
        fill_directed();
        #1;
        check_eq("rv_prog_addr", prog_addr2, 16'hFFFE);
        @(posedge clk);
        #1;
        rst2_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 5 && !seen; k++) begin
            @(negedge clk);
            seen = instr_valid2;
        end
        check_eq("rv_start", instr_valid2, 1);
        check_eq("rv_pc0", instr_pc2, 16'hFFFE);
        @(negedge clk);
        check_eq("rv_pc1", instr_pc2, 16'hFFFF);
        @(negedge clk);
        check_eq("rv_pc2", instr_pc2, 16'h0000);
        @(negedge clk);
        check_eq("rv_pc3", instr_pc2, 16'h0001);
        @(posedge clk);
        #3;
        rst2_n = 1'b0;
        #1;
        check_eq("rv_rst_valid", instr_valid2, 0);
        check_eq("rv_rst_addr", prog_addr2, 16'hFFFE);
        @(posedge clk);
        #1;
        rst2_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 5 && !seen; k++) begin
            @(negedge clk);
            seen = instr_valid2;
        end
        check_eq("rv_restart", instr_valid2, 1);
        check_eq("rv_restart_pc", instr_pc2, 16'hFFFE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
